// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan controller.
//   scan_state_e : FSM state encoding (IDLE, SETTLE, CAPTURE)
//   NUM_CH/SEL_W : channel count and select width of the 8:1 selector
//   scan_hit_t   : result of a set-bit search (found flag + channel index)
//   next_set_bit : lowest set bit of mask at or above index 'from'
package mux_scan_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE
  } scan_state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } scan_hit_t;

  // 'from' is one bit wider than a channel index so that "one past the
  // highest channel" is representable and simply yields found = 0.
  // Scanning downward leaves the lowest qualifying index in the result.
  function automatic scan_hit_t next_set_bit(input logic [NUM_CH-1:0] mask,
                                             input logic [SEL_W:0]    from);
    scan_hit_t hit;
    hit = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        hit.found = 1'b1;
        hit.idx   = SEL_W'(i);
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/scan_settle_cnt.sv
// Settle-window down-counter.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val this cycle (takes priority over counting)
//   load_val  : value loaded; the counter then runs down to zero
//   expired   : count is zero (window finished)
module scan_settle_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       expired
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == 4'd0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller for an external 8:1 bit selector. Walks the enabled
// channels of a latched mask in ascending order, holds each select for
// SETTLE_CYCLES+1 cycles, captures the returned bit and publishes the
// assembled frame with a one-cycle valid pulse.
//   clk, rst  : clock, synchronous active-high reset
//   start     : request a frame (only honoured in IDLE)
//   cont      : restart automatically at the end of each frame
//   mask[7:0] : channel enables, latched at frame start
//   sel[2:0]  : registered channel select to the selector
//   mux_bit   : bit returned by the selector
//   data_out  : last completed frame (bit i = channel i, 0 if disabled)
//   valid     : one-cycle pulse when data_out is updated
//   busy      : FSM not in IDLE
// Handshake: valid is a single-cycle strobe with no back-pressure; start is
// a level sampled only while busy is low.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic [NUM_CH-1:0] mask,
  output logic [SEL_W-1:0]  sel,
  input  logic              mux_bit,
  output logic [NUM_CH-1:0] data_out,
  output logic              valid,
  output logic              busy
);

  // The SETTLE state covers the first SETTLE_CYCLES cycles of a window and
  // CAPTURE its final cycle; with no settle time a channel enters CAPTURE
  // directly.
  localparam logic [3:0]  SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  localparam scan_state_e CH_ENTRY_ST = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_CAPTURE;

  scan_state_e       state_q,    state_d;
  logic [SEL_W-1:0]  sel_q,      sel_d;
  logic [NUM_CH-1:0] data_out_q, data_out_d;
  logic              valid_q,    valid_d;
  logic              busy_q,     busy_d;
  logic [NUM_CH-1:0] mask_q,     mask_d;
  logic [NUM_CH-1:0] frame_q,    frame_d;

  logic              cnt_load;
  logic              cnt_expired;
  logic [SEL_W:0]    next_from;
  scan_hit_t         hit_first;
  scan_hit_t         hit_next;

  scan_settle_cnt u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .expired  (cnt_expired)
  );

  assign next_from = {1'b0, sel_q} + (SEL_W + 1)'(1);
  assign hit_first = next_set_bit(mask, '0);
  assign hit_next  = next_set_bit(mask_q, next_from);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    mask_d     = mask_q;
    frame_d    = frame_q;
    cnt_load   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d  = mask;
          frame_d = '0;
          if (hit_first.found) begin
            sel_d    = hit_first.idx;
            state_d  = CH_ENTRY_ST;
            cnt_load = 1'b1;
          end else begin
            // Empty frame completes at the accept edge itself.
            valid_d    = 1'b1;
            data_out_d = '0;
          end
        end
      end

      ST_SETTLE: begin
        if (cnt_expired) begin
          state_d = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        // Guard keeps an empty continuous-mode frame from writing a bit.
        if (mask_q[sel_q]) begin
          frame_d[sel_q] = mux_bit;
        end
        if (hit_next.found) begin
          sel_d    = hit_next.idx;
          state_d  = CH_ENTRY_ST;
          cnt_load = 1'b1;
        end else begin
          // Publish the frame including the bit captured this edge, then
          // optionally restart from a freshly latched mask.
          data_out_d = frame_d;
          valid_d    = 1'b1;
          if (cont) begin
            mask_d  = mask;
            frame_d = '0;
            if (hit_first.found) begin
              sel_d    = hit_first.idx;
              state_d  = CH_ENTRY_ST;
              cnt_load = 1'b1;
            end else begin
              // Empty frame in continuous mode: finish it on the next edge.
              state_d = ST_CAPTURE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      mask_q     <= '0;
      frame_q    <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      mask_q     <= mask_d;
      frame_q    <= frame_d;
    end
  end

  assign sel      = sel_q;
  assign data_out = data_out_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl with a behavioural 8:1 selector. Directed frames
// push their expected data and valid cycle into a queue; a monitor pops on
// every valid pulse and compares.
module tb_mux_scan_ctrl;

  localparam int S = 1;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic [7:0] mask = 8'h00;
  logic [7:0] in_vec = 8'h00;
  logic [2:0] sel;
  logic       mux_bit;
  logic [7:0] data_out;
  logic       valid;
  logic       busy;

  int chk = 0;
  int err = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mux_bit = in_vec[sel];

  mux_scan_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cont     (cont),
    .mask     (mask),
    .sel      (sel),
    .mux_bit  (mux_bit),
    .data_out (data_out),
    .valid    (valid),
    .busy     (busy)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk++;
    if (act !== req) begin
      err++;
      $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, req);
    end
  endtask

  // Drive a start pulse at a negedge; returns at the negedge after the
  // accept edge. Expected frame and valid cycle go into the scoreboard.
  task automatic issue(input logic [7:0] m, input logic [7:0] exp_data, input int n,
                       output int vcyc);
    mask  = m;
    start = 1'b1;
    vcyc  = cyc + 1 + n * (S + 1);
    exp_q.push_back(exp_data);
    exp_cyc_q.push_back(vcyc);
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [7:0] ed;
    int         ec;
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk++;
        err++;
        $display("FAIL unexpected_valid at cycle %0d: data_out %0h", cyc, data_out);
      end else begin
        ed = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("frame_data", 32'(data_out), 32'(ed));
        check("frame_latency", 32'(cyc), 32'(ec));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    err++;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int vc;

    repeat (3) @(negedge clk);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full mask: each channel held 2 cycles, valid 16 cycles after accept.
    in_vec = 8'hA5;
    issue(8'hFF, 8'hA5, 8, vc);
    for (int k = 0; k < 16; k++) begin
      check("full_sel", 32'(sel), 32'(k / 2));
      check("full_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    check("full_busy_fall", 32'(busy), 32'd0);
    check("full_valid", 32'(valid), 32'd1);
    repeat (3) @(negedge clk);
    check("idle_hold_data", 32'(data_out), 32'hA5);
    check("idle_hold_sel", 32'(sel), 32'd7);
    check("idle_valid_low", 32'(valid), 32'd0);

    // Sparse mask: only channels 0 and 7 visited.
    in_vec = 8'hFF;
    issue(8'h81, 8'h81, 2, vc);
    for (int k = 0; k < 4; k++) begin
      check("sparse_sel", 32'(sel), (k < 2) ? 32'd0 : 32'd7);
      @(negedge clk);
    end
    check("sparse_busy_fall", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    // Empty mask: valid at the accept edge, sel untouched.
    issue(8'h00, 8'h00, 0, vc);
    check("empty_sel_hold", 32'(sel), 32'd7);
    check("empty_busy", 32'(busy), 32'd0);
    check("empty_data", 32'(data_out), 32'h00);
    repeat (2) @(negedge clk);
    check("empty_valid_low", 32'(valid), 32'd0);

    // Continuous mode: two back-to-back frames, cont dropped mid-frame 2.
    cont   = 1'b1;
    in_vec = 8'h03;
    issue(8'h0F, 8'h03, 4, vc);
    exp_q.push_back(8'h0C);
    exp_cyc_q.push_back(vc + 8);
    repeat (8) @(negedge clk);
    check("cont_busy_held", 32'(busy), 32'd1);
    check("cont_restart_sel", 32'(sel), 32'd0);
    in_vec = 8'h0C;
    repeat (4) @(negedge clk);
    cont = 1'b0;
    repeat (4) @(negedge clk);
    check("cont_end_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("cont_stays_idle", 32'(busy), 32'd0);

    // Reset mid-frame: partial frame discarded, no valid.
    in_vec = 8'h5A;
    mask   = 8'hFF;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sel", 32'(sel), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data", 32'(data_out), 32'h00);
    check("midrst_valid", 32'(valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    issue(8'h3C, 8'h18, 4, vc);
    repeat (8) @(negedge clk);
    check("postrst_busy", 32'(busy), 32'd0);

    // Ignored inputs: start and mask change while busy.
    in_vec = 8'h96;
    issue(8'hF0, 8'h90, 4, vc);
    repeat (3) @(negedge clk);
    start = 1'b1;
    mask  = 8'h00;
    @(negedge clk);
    start = 1'b0;
    check("ignore_busy", 32'(busy), 32'd1);
    check("ignore_sel", 32'(sel), 32'd6);
    repeat (4) @(negedge clk);
    check("ignore_done_busy", 32'(busy), 32'd0);
    check("ignore_data", 32'(data_out), 32'h90);
    repeat (3) @(negedge clk);
    check("ignore_no_restart", 32'(busy), 32'd0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL take parameter SETTLE_CYCLES, default 1, range 0..15: extra cycles sel is held before the bit is captured.
REQ-003 The block SHALL have these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  requests a scan frame; sampled only in IDLE.
- cont  in  1  enables continuous mode; a new frame starts automatically after each frame.
- mask  in  8  per-channel enable; bit i = 1 means channel i is scanned.
- sel  out  3  channel select to the 8:1 bit selector.
- mux_bit  in  1  selected bit returned from the selector.
- data_out  out  8  assembled frame; bit i = captured value of channel i.
- valid  out  1  one-cycle pulse; data_out is new.
- busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-004 FSM states SHALL be IDLE, SETTLE and CAPTURE.
REQ-005 In IDLE, start=1 at an edge SHALL latch mask into mask_q, clear the frame register, and go to SETTLE with sel = lowest set bit of mask; that edge is the accept edge.
REQ-006 If the mask latched at accept is 0x00, the block SHALL skip SETTLE, return to IDLE, and pulse valid with data_out=0x00 at the next edge.
REQ-007 For each enabled channel, sel SHALL be held stable for exactly SETTLE_CYCLES+1 cycles, and mux_bit SHALL be captured into frame bit sel at the last edge of that window.
REQ-008 At each capture, sel SHALL advance to the next higher set bit of mask_q; disabled channels SHALL be skipped in zero cycles and SHALL read 0 in data_out.
REQ-009 At the capture of the highest enabled channel, the block SHALL load data_out with the completed frame and set valid=1 for exactly one cycle.
REQ-010 Latency from accept edge to the valid edge SHALL be N*(SETTLE_CYCLES+1) cycles, where N = popcount(mask_q).
REQ-011 On completion with cont=1, the block SHALL re-latch mask and start a new frame at the same edge, with no IDLE cycle and busy held high.
REQ-012 On completion with cont=0, the block SHALL return to IDLE.
REQ-013 Deasserting cont mid-frame SHALL let the current frame finish normally.
REQ-014 start while busy SHALL be ignored.
REQ-015 Changes to mask mid-frame SHALL have no effect until the next re-latch.
REQ-016 In IDLE, sel SHALL hold its last value and data_out SHALL hold the last frame until the next valid.
REQ-017 All outputs SHALL be registered, with no combinational path from mux_bit to any output.

Reset
REQ-018 rst=1 SHALL force: state=IDLE, sel=0, data_out=0x00, valid=0, busy=0, mask_q=0x00, frame register=0x00, settle counter=0.
REQ-019 rst asserted mid-frame SHALL discard the partial frame, with no valid pulse; reset SHALL take priority over start and cont at the same edge.

Structure
REQ-020 Package mux_scan_pkg SHALL hold: the state enum type, NUM_CH=8, SEL_W=3, and the next-set-bit search function (argument: mask and current index).
REQ-021 Settle timing SHALL live in one sub-module, scan_settle_cnt: a 4-bit down-counter with load/expire; there SHALL be no other sub-modules.

Verification
REQ-022 The bench SHALL model the selector behaviourally (mux_bit = in_vec[sel]) and cover at least these scenarios:
- Full mask: SETTLE_CYCLES=1, in_vec=0xA5, mask=0xFF, start pulse -> sel steps 0..7, each held 2 cycles; valid 16 cycles after accept; data_out=0xA5; busy falls with valid.
- Sparse mask: in_vec=0xFF, mask=0x81 -> only sel 0 and 7 are driven; valid after 4 cycles; data_out=0x81.
- Empty mask: mask=0x00, start -> valid at the next edge; data_out=0x00; sel unchanged.
- Continuous mode: cont=1, mask=0x0F, in_vec changes 0x03 then 0x0C between frames -> back-to-back valids 8 cycles apart with data 0x03 then 0x0C; cont dropped mid-frame 2 -> frame 2 completes, then IDLE.
- Reset mid-frame: rst at cycle 5 of a 0xFF frame -> next cycle sel=0, busy=0, data_out=0x00, and no valid; a subsequent start runs a clean frame.
- Ignored inputs: start pulse and mask change to 0x00 during a busy frame -> no restart, and the original mask frame completes correctly.
